// File: rtl/writeback.sv
// MIPS write-back stage: selects ALU/load/link result and drives the register file write port.
// Optional load-timeout supervision is enabled with the WB_LOAD_TIMEOUT_EN macro.
`ifndef DWIDTH
`define DWIDTH 32
`endif
`ifndef AWIDTH
`define AWIDTH 5
`endif

module writeback #(
    parameter int DWIDTH  = `DWIDTH,
    parameter int AWIDTH  = `AWIDTH,
    parameter int TIMEOUT = 15
) (
    input  logic              w_clk,
    input  logic              w_rst,
    input  logic              w_in_valid,
    output logic              w_in_ready,
    input  logic              w_in_regwrite,
    input  logic [1:0]        w_in_sel,
    input  logic [AWIDTH-1:0] w_in_rd,
    input  logic [DWIDTH-1:0] w_in_alu,
    input  logic [DWIDTH-1:0] w_in_link,
    input  logic              w_mem_rvalid,
    input  logic [DWIDTH-1:0] w_mem_rdata,
    input  logic              w_flush,
    output logic              w_wr_en,
    output logic [AWIDTH-1:0] w_wr_addr,
    output logic [DWIDTH-1:0] w_wr_data,
    output logic              w_fwd_busy,
    output logic [AWIDTH-1:0] w_fwd_addr,
    output logic              w_err
);

    typedef enum logic [0:0] {
        IDLE      = 1'b0,
        WAIT_LOAD = 1'b1
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;
    logic                wr_en_r;
    logic                wr_en_nxt_s;
    logic [AWIDTH-1:0]   wr_addr_r;
    logic [AWIDTH-1:0]   wr_addr_nxt_s;
    logic [DWIDTH-1:0]   wr_data_r;
    logic [DWIDTH-1:0]   wr_data_nxt_s;
    logic [AWIDTH-1:0]   rd_r;
    logic [AWIDTH-1:0]   rd_nxt_s;
    logic [DWIDTH-1:0]   sel_data_s;
    logic                accept_s;
    logic                eff_s;
    logic                is_load_s;
    logic                timeout_s;
    logic                err_set_s;

    assign w_in_ready = (state_r == IDLE);
    assign accept_s   = w_in_ready && w_in_valid && !w_flush;
    // Writes to $0 never reach the register file.
    assign eff_s      = w_in_regwrite && (w_in_rd != {AWIDTH{1'b0}});
    assign is_load_s  = (w_in_sel == 2'b01);

    // Source mux for non-load results; reserved encoding falls back to ALU.
    always_comb begin
        sel_data_s = w_in_alu;
        case (w_in_sel)
            2'b10:   sel_data_s = w_in_link;
            default: sel_data_s = w_in_alu;
        endcase
    end

`ifdef WB_LOAD_TIMEOUT_EN
    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_r;
    logic          err_r;

    assign timeout_s = (cnt_r == CW'(TIMEOUT - 1));
    assign w_err     = err_r;

    // Wait counter: held at zero in IDLE, so every new load starts from zero.
    always_ff @(posedge w_clk or negedge w_rst) begin
        if (!w_rst) begin
            cnt_r <= {CW{1'b0}};
        end else if (state_r == WAIT_LOAD) begin
            cnt_r <= cnt_r + CW'(1);
        end else begin
            cnt_r <= {CW{1'b0}};
        end
    end

    // Sticky load-timeout flag, cleared only by reset.
    always_ff @(posedge w_clk or negedge w_rst) begin
        if (!w_rst) begin
            err_r <= 1'b0;
        end else begin
            err_r <= err_r | err_set_s;
        end
    end
`else
    logic [31:0] unused_timeout_s;

    // Without supervision a load waits forever; the parameter is kept for interface compatibility.
    assign unused_timeout_s = 32'(TIMEOUT);
    assign timeout_s        = 1'b0;
    assign w_err            = 1'b0;
`endif

    // Next-state and write-port decode; flush has priority over rvalid, rvalid over timeout.
    always_comb begin
        state_nxt_s   = state_r;
        wr_en_nxt_s   = 1'b0;
        wr_addr_nxt_s = wr_addr_r;
        wr_data_nxt_s = wr_data_r;
        rd_nxt_s      = rd_r;
        err_set_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (accept_s && eff_s) begin
                    if (is_load_s) begin
                        state_nxt_s = WAIT_LOAD;
                        rd_nxt_s    = w_in_rd;
                    end else begin
                        wr_en_nxt_s   = 1'b1;
                        wr_addr_nxt_s = w_in_rd;
                        wr_data_nxt_s = sel_data_s;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WAIT_LOAD: begin
                if (w_flush) begin
                    state_nxt_s = IDLE;
                end else if (w_mem_rvalid) begin
                    state_nxt_s   = IDLE;
                    wr_en_nxt_s   = 1'b1;
                    wr_addr_nxt_s = rd_r;
                    wr_data_nxt_s = w_mem_rdata;
                end else if (timeout_s) begin
                    state_nxt_s = IDLE;
                    err_set_s   = 1'b1;
                end else begin
                    state_nxt_s = WAIT_LOAD;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State, pending destination and registered write port.
    always_ff @(posedge w_clk or negedge w_rst) begin
        if (!w_rst) begin
            state_r   <= IDLE;
            rd_r      <= {AWIDTH{1'b0}};
            wr_en_r   <= 1'b0;
            wr_addr_r <= {AWIDTH{1'b0}};
            wr_data_r <= {DWIDTH{1'b0}};
        end else begin
            state_r   <= state_nxt_s;
            rd_r      <= rd_nxt_s;
            wr_en_r   <= wr_en_nxt_s;
            wr_addr_r <= wr_addr_nxt_s;
            wr_data_r <= wr_data_nxt_s;
        end
    end

    assign w_wr_en    = wr_en_r;
    assign w_wr_addr  = wr_addr_r;
    assign w_wr_data  = wr_data_r;
    assign w_fwd_busy = (state_r == WAIT_LOAD);
    assign w_fwd_addr = w_fwd_busy ? rd_r : {AWIDTH{1'b0}};

endmodule

// File: tb/tb_writeback.sv
// Directed self-checking bench for the writeback stage (default 32-bit data, 5-bit address, TIMEOUT 15).
`timescale 1ns/1ps

module tb_writeback;

    logic        w_clk = 1'b0;
    logic        w_rst;
    logic        w_in_valid;
    logic        w_in_ready;
    logic        w_in_regwrite;
    logic [1:0]  w_in_sel;
    logic [4:0]  w_in_rd;
    logic [31:0] w_in_alu;
    logic [31:0] w_in_link;
    logic        w_mem_rvalid;
    logic [31:0] w_mem_rdata;
    logic        w_flush;
    logic        w_wr_en;
    logic [4:0]  w_wr_addr;
    logic [31:0] w_wr_data;
    logic        w_fwd_busy;
    logic [4:0]  w_fwd_addr;
    logic        w_err;

    int passed = 0;
    int total  = 0;

    writeback #(.DWIDTH(32), .AWIDTH(5), .TIMEOUT(15)) dut (
        .w_clk         (w_clk),
        .w_rst         (w_rst),
        .w_in_valid    (w_in_valid),
        .w_in_ready    (w_in_ready),
        .w_in_regwrite (w_in_regwrite),
        .w_in_sel      (w_in_sel),
        .w_in_rd       (w_in_rd),
        .w_in_alu      (w_in_alu),
        .w_in_link     (w_in_link),
        .w_mem_rvalid  (w_mem_rvalid),
        .w_mem_rdata   (w_mem_rdata),
        .w_flush       (w_flush),
        .w_wr_en       (w_wr_en),
        .w_wr_addr     (w_wr_addr),
        .w_wr_data     (w_wr_data),
        .w_fwd_busy    (w_fwd_busy),
        .w_fwd_addr    (w_fwd_addr),
        .w_err         (w_err)
    );

    always #5 w_clk = ~w_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Advance one clock; outputs are sampled 1 ns after the rising edge.
    task automatic step();
        @(posedge w_clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic rw, input logic [1:0] sel,
                         input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] link);
        w_in_valid    = v;
        w_in_regwrite = rw;
        w_in_sel      = sel;
        w_in_rd       = rd;
        w_in_alu      = alu;
        w_in_link     = link;
    endtask

    initial begin
        w_rst        = 1'b0;
        w_mem_rvalid = 1'b0;
        w_mem_rdata  = 32'h0;
        w_flush      = 1'b0;
        drive(1'b0, 1'b0, 2'b00, 5'd0, 32'h0, 32'h0);
        #12;
        check("rst_wr_en",    {31'd0, w_wr_en},    32'd0);
        check("rst_wr_addr",  {27'd0, w_wr_addr},  32'd0);
        check("rst_wr_data",  w_wr_data,           32'd0);
        check("rst_busy",     {31'd0, w_fwd_busy}, 32'd0);
        check("rst_fwd_addr", {27'd0, w_fwd_addr}, 32'd0);
        check("rst_err",      {31'd0, w_err},      32'd0);
        check("rst_ready",    {31'd0, w_in_ready}, 32'd1);
        @(negedge w_clk);
        w_rst = 1'b1;
        step();

        // ALU write to r8
        drive(1'b1, 1'b1, 2'b00, 5'd8, 32'h0000_1234, 32'h0);
        step();
        drive(1'b0, 1'b0, 2'b00, 5'd0, 32'h0, 32'h0);
        check("alu_wr_en",   {31'd0, w_wr_en},   32'd1);
        check("alu_wr_addr", {27'd0, w_wr_addr}, 32'd8);
        check("alu_wr_data", w_wr_data,          32'h0000_1234);
        step();
        check("alu_pulse_end", {31'd0, w_wr_en},   32'd0);
        check("alu_addr_hold", {27'd0, w_wr_addr}, 32'd8);
        check("alu_data_hold", w_wr_data,          32'h0000_1234);

        // Link select and reserved select
        drive(1'b1, 1'b1, 2'b10, 5'd31, 32'hDEAD_0000, 32'h0040_0008);
        step();
        check("link_wr_addr", {27'd0, w_wr_addr}, 32'd31);
        check("link_wr_data", w_wr_data,          32'h0040_0008);
        drive(1'b1, 1'b1, 2'b11, 5'd5, 32'h0000_0055, 32'h1111_1111);
        step();
        check("rsv_wr_en",   {31'd0, w_wr_en}, 32'd1);
        check("rsv_wr_data", w_wr_data,        32'h0000_0055);

        // $0 suppression and regwrite=0
        drive(1'b1, 1'b1, 2'b00, 5'd0, 32'h0000_0099, 32'h0);
        step();
        check("r0_wr_en",     {31'd0, w_wr_en},    32'd0);
        check("r0_ready",     {31'd0, w_in_ready}, 32'd1);
        check("r0_addr_hold", {27'd0, w_wr_addr},  32'd5);
        drive(1'b1, 1'b0, 2'b00, 5'd7, 32'h0000_0077, 32'h0);
        step();
        check("norw_wr_en", {31'd0, w_wr_en}, 32'd0);

        // Load to r3: rvalid in acceptance cycle is ignored, real data after 4 idle wait cycles
        drive(1'b1, 1'b1, 2'b01, 5'd3, 32'h0, 32'h0);
        w_mem_rvalid = 1'b1;
        w_mem_rdata  = 32'h0000_0BAD;
        step();
        drive(1'b1, 1'b1, 2'b00, 5'd9, 32'h0000_0999, 32'h0);
        w_mem_rvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("ld_busy",     {31'd0, w_fwd_busy}, 32'd1);
            check("ld_fwd_addr", {27'd0, w_fwd_addr}, 32'd3);
            check("ld_ready",    {31'd0, w_in_ready}, 32'd0);
            check("ld_no_wr",    {31'd0, w_wr_en},    32'd0);
            if (i < 4) step();
        end
        drive(1'b0, 1'b0, 2'b00, 5'd0, 32'h0, 32'h0);
        w_mem_rvalid = 1'b1;
        w_mem_rdata  = 32'h0000_CAFE;
        step();
        w_mem_rvalid = 1'b0;
        check("ld_wr_en",     {31'd0, w_wr_en},    32'd1);
        check("ld_wr_addr",   {27'd0, w_wr_addr},  32'd3);
        check("ld_wr_data",   w_wr_data,           32'h0000_CAFE);
        check("ld_busy_end",  {31'd0, w_fwd_busy}, 32'd0);
        check("ld_fwd_clear", {27'd0, w_fwd_addr}, 32'd0);
        check("ld_ready_end", {31'd0, w_in_ready}, 32'd1);
        step();
        check("ld_single_pulse", {31'd0, w_wr_en}, 32'd0);

        // Flush wins over simultaneous rvalid
        drive(1'b1, 1'b1, 2'b01, 5'd4, 32'h0, 32'h0);
        step();
        drive(1'b0, 1'b0, 2'b00, 5'd0, 32'h0, 32'h0);
        w_flush      = 1'b1;
        w_mem_rvalid = 1'b1;
        w_mem_rdata  = 32'h0000_0077;
        step();
        w_flush      = 1'b0;
        w_mem_rvalid = 1'b0;
        check("flush_no_wr", {31'd0, w_wr_en},    32'd0);
        check("flush_idle",  {31'd0, w_in_ready}, 32'd1);
        check("flush_busy",  {31'd0, w_fwd_busy}, 32'd0);
        step();
        check("flush_no_late_wr", {31'd0, w_wr_en},   32'd0);
        check("flush_addr_hold",  {27'd0, w_wr_addr}, 32'd3);

        // Flush in IDLE blocks acceptance (ALU and load)
        drive(1'b1, 1'b1, 2'b00, 5'd9, 32'h0000_0009, 32'h0);
        w_flush = 1'b1;
        step();
        check("idle_flush_no_wr", {31'd0, w_wr_en}, 32'd0);
        drive(1'b1, 1'b1, 2'b01, 5'd9, 32'h0, 32'h0);
        step();
        w_flush = 1'b0;
        check("idle_flush_no_load", {31'd0, w_fwd_busy}, 32'd0);

        // Load without effective write is not waited for
        drive(1'b1, 1'b1, 2'b01, 5'd0, 32'h0, 32'h0);
        step();
        check("ld_r0_ready", {31'd0, w_in_ready}, 32'd1);
        check("ld_r0_busy",  {31'd0, w_fwd_busy}, 32'd0);

        // Back-to-back ALU writes to r1, r2, r3
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 1'b1, 2'b00, 5'(i), 32'h0000_0100 + 32'(i), 32'h0);
            step();
            check("b2b_wr_en",   {31'd0, w_wr_en},   32'd1);
            check("b2b_wr_addr", {27'd0, w_wr_addr}, 32'(i));
            check("b2b_wr_data", w_wr_data,          32'h0000_0100 + 32'(i));
        end
        drive(1'b0, 1'b0, 2'b00, 5'd0, 32'h0, 32'h0);
        step();
        check("b2b_end", {31'd0, w_wr_en}, 32'd0);

`ifdef WB_LOAD_TIMEOUT_EN
        // Timeout: 15 wait cycles without rvalid
        drive(1'b1, 1'b1, 2'b01, 5'd10, 32'h0, 32'h0);
        step();
        drive(1'b0, 1'b0, 2'b00, 5'd0, 32'h0, 32'h0);
        for (int i = 1; i <= 14; i++) begin
            step();
            check("to_still_busy", {31'd0, w_fwd_busy}, 32'd1);
            check("to_err_low",    {31'd0, w_err},      32'd0);
        end
        step();
        check("to_err",   {31'd0, w_err},      32'd1);
        check("to_ready", {31'd0, w_in_ready}, 32'd1);
        check("to_no_wr", {31'd0, w_wr_en},    32'd0);
        drive(1'b1, 1'b1, 2'b00, 5'd12, 32'h0000_00AB, 32'h0);
        step();
        drive(1'b0, 1'b0, 2'b00, 5'd0, 32'h0, 32'h0);
        check("to_traffic_wr", {31'd0, w_wr_en}, 32'd1);
        check("to_err_sticky", {31'd0, w_err},   32'd1);
`else
        // Without supervision a load keeps waiting well past TIMEOUT
        drive(1'b1, 1'b1, 2'b01, 5'd10, 32'h0, 32'h0);
        step();
        drive(1'b0, 1'b0, 2'b00, 5'd0, 32'h0, 32'h0);
        for (int i = 0; i < 20; i++) step();
        check("nto_busy", {31'd0, w_fwd_busy}, 32'd1);
        check("nto_err",  {31'd0, w_err},      32'd0);
        w_flush = 1'b1;
        step();
        w_flush = 1'b0;
        check("nto_flush_idle", {31'd0, w_in_ready}, 32'd1);
`endif

        // Reset mid-wait loses the pending load
        drive(1'b1, 1'b1, 2'b01, 5'd6, 32'h0, 32'h0);
        step();
        drive(1'b0, 1'b0, 2'b00, 5'd0, 32'h0, 32'h0);
        check("mw_busy", {31'd0, w_fwd_busy}, 32'd1);
        w_rst = 1'b0;
        #2;
        check("mw_rst_busy", {31'd0, w_fwd_busy}, 32'd0);
        check("mw_rst_err",  {31'd0, w_err},      32'd0);
        @(negedge w_clk);
        w_rst        = 1'b1;
        w_mem_rvalid = 1'b1;
        w_mem_rdata  = 32'h0000_6666;
        step();
        w_mem_rvalid = 1'b0;
        check("mw_no_wr",   {31'd0, w_wr_en},    32'd0);
        check("mw_wr_addr", {27'd0, w_wr_addr},  32'd0);
        check("mw_ready",   {31'd0, w_in_ready}, 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/writeback.md
# writeback

Write-back stage of the MIPS pipeline and sole driver of the register file write port (write enable, write address, write data). It accepts one retiring instruction per cycle from the MEM stage and selects the ALU result, load data or link address. It waits a variable number of cycles for load data, then issues a single-cycle write pulse. Write outputs are registered on the rising edge so they are stable when the register file writes on the falling edge of the same cycle.

## Interface
Parameters:
- DWIDTH, default `DWIDTH (32): data width.
- AWIDTH, default `AWIDTH (5): register address width.
- TIMEOUT, default 15: maximum number of cycles spent waiting for load data.

Ports:
- w_clk  in  1  clock; rising edge.
- w_rst  in  1  asynchronous reset, active-low.
- w_in_valid  in  1  MEM stage presents an instruction.
- w_in_ready  out  1  stage can accept; combinational, equal to (state == IDLE).
- w_in_regwrite  in  1  instruction writes a register.
- w_in_sel  in  2  source select: 00 = ALU, 01 = load, 10 = link, 11 = reserved (treated as ALU).
- w_in_rd  in  AWIDTH  destination register.
- w_in_alu  in  DWIDTH  ALU result.
- w_in_link  in  DWIDTH  PC+8 link value.
- w_mem_rvalid  in  1  load data valid.
- w_mem_rdata  in  DWIDTH  load data.
- w_flush  in  1  discard the current or pending instruction.
- w_wr_en  out  1  register file write enable; one-cycle pulse.
- w_wr_addr  out  AWIDTH  register file write address.
- w_wr_data  out  DWIDTH  register file write data.
- w_fwd_busy  out  1  a load destination is pending.
- w_fwd_addr  out  AWIDTH  pending load destination.
- w_err  out  1  sticky load-timeout flag.

## Operation
- FSM has two states: IDLE and WAIT_LOAD. Reset state is IDLE.
- Acceptance occurs when state is IDLE, w_in_valid = 1 and w_flush = 0.
- Effective write: w_in_regwrite = 1 and w_in_rd != 0. Writes to $0 are always suppressed.
- ALU or link accepted with an effective write: the next cycle has w_wr_en = 1, w_wr_addr = rd and w_wr_data = the selected value. State stays IDLE.
- Load accepted with an effective write: state goes to WAIT_LOAD. The instruction's rd is latched and the wait counter is cleared.
- Load accepted without an effective write: the load is not waited for and the stage stays IDLE.
- WAIT_LOAD with w_mem_rvalid = 1: w_mem_rdata is latched, w_wr_en pulses in the next cycle, and state returns to IDLE.
- WAIT_LOAD with no rvalid: the counter increments. When it reaches TIMEOUT, w_err is set (sticky until reset), the write is dropped and state returns to IDLE.
- w_flush in IDLE: nothing is accepted that cycle.
- w_flush in WAIT_LOAD: the load is aborted, no write occurs, and state returns to IDLE.
- Flush wins over a simultaneous rvalid.
- w_mem_rvalid is ignored in IDLE, including in the acceptance cycle itself.
- w_fwd_busy = 1 exactly while in WAIT_LOAD. w_fwd_addr = latched rd while busy, otherwise 0.
- Reset values: w_wr_en = 0, w_wr_addr = 0, w_wr_data = 0, w_fwd_busy = 0, w_fwd_addr = 0, w_err = 0, w_in_ready = 1.
- Reset asserted mid-wait: the pending load is lost and no write is issued.

## Timing
- ALU/link latency: 1 cycle from acceptance edge to w_wr_en high.
- Load latency: 1 cycle after the rvalid edge.
- Throughput: 1 instruction per cycle for ALU/link; a write pulse and a new acceptance may occur in the same cycle.
- w_wr_en is never high for 2 cycles from the same instruction.
- w_wr_addr and w_wr_data hold their last values when w_wr_en = 0.
- A timeout fires on the TIMEOUT-th WAIT_LOAD cycle without rvalid. w_err rises in the following cycle, at the same time w_in_ready returns high.

## Configuration
- Macro WB_LOAD_TIMEOUT_EN.
- When defined: the counter and w_err exist as described above.
- When undefined: WAIT_LOAD waits indefinitely for rvalid or flush, w_err is tied to 0, and TIMEOUT is unused.

## Test plan
- ALU write: reset, then accept sel = 00, rd = 8, alu = 0x1234 -> next cycle wr_en = 1, addr = 8, data = 0x1234; following cycle wr_en = 0.
- $0 suppression: accept rd = 0, regwrite = 1 -> wr_en stays 0 and in_ready stays 1.
- Load with wait: accept sel = 01, rd = 3, then rvalid with 0xCAFE after 4 cycles -> fwd_busy = 1 and fwd_addr = 3 for 5 cycles (acceptance edge through the rvalid cycle), in_ready = 0 over the same cycles, then wr_en = 1, addr = 3, data = 0xCAFE.
- Flush versus rvalid: flush and rvalid asserted in the same WAIT_LOAD cycle -> no write, state returns to IDLE.
- Timeout (macro defined): TIMEOUT = 15, no rvalid -> w_err = 1 after 15 wait cycles, no write, w_err stays 1 across later traffic until reset.
- Back-to-back: 3 consecutive ALU instructions to rd = 1, 2, 3 -> 3 consecutive wr_en pulses with matching addresses.
